// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types and register offsets for the performance counter bank
// Purpose: register map constants, control-bit layout and counter address helper.
// Ports: none (package).
package rv32i_types;

  localparam logic [7:0] PERF_CNT_BASE  = 8'h00;
  localparam logic [7:0] PERF_HI_BASE   = 8'h80;
  localparam logic [7:0] PERF_OVF_ADDR  = 8'hF8;
  localparam logic [7:0] PERF_CTRL_ADDR = 8'hFC;

  // Field order puts freeze in bit 0, saturate in bit 1, clear_all in bit 2.
  typedef struct packed {
    logic clear_all;
    logic saturate;
    logic freeze;
  } perf_ctrl_t;

  // Byte offset of counter k's low word (hi=0) or high word (hi=1).
  function automatic logic [7:0] counter_addr(input int k, input bit hi);
    return (hi ? PERF_HI_BASE : PERF_CNT_BASE) + 8'(4 * k);
  endfunction

endpackage

// File: rtl/perf_counter_bank_counter.sv
// rtl/perf_counter_bank_counter.sv - one event counter cell with load, clear and overflow handling
// Purpose: a single CNT_WIDTH counter; priority is clear, then bus load, then increment.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   inc              count one event this cycle
//   load             32-bit load data from the bus
//   load_lo/load_hi  load bits 31:0 / bits CNT_WIDTH-1:32 from load
//   clear            zero the counter
//   saturate         hold at all-ones instead of wrapping
//   value            current count
//   ovf_set          pulses when an increment hits the all-ones value
module perf_counter
  import rv32i_types::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic [31:0]          load,
  input  logic                 load_hi,
  input  logic                 load_lo,
  input  logic                 clear,
  input  logic                 saturate,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 ovf_set
);

  logic [CNT_WIDTH-1:0] value_q, value_d;
  logic [CNT_WIDTH-1:0] loaded;

  generate
    if (CNT_WIDTH > 32) begin : g_wide
      assign loaded = {load_hi ? load[CNT_WIDTH-33:0] : value_q[CNT_WIDTH-1:32],
                       load_lo ? load : value_q[31:0]};
    end else begin : g_narrow
      // No high word exists, so a stray high-word strobe leaves the value alone.
      assign loaded = load_hi ? value_q : load[CNT_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    value_d = value_q;
    ovf_set = 1'b0;
    if (clear) begin
      value_d = '0;
    end else if (load_lo || load_hi) begin
      value_d = loaded;
    end else if (inc) begin
      if (&value_q) begin
        ovf_set = 1'b1;
        value_d = saturate ? value_q : '0;
      end else begin
        value_d = value_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event counters with a register read/write port
// Purpose: address decode, control/overflow registers, high-word snapshot and registered response.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   event_i[NUM_CNT]       per-counter increment request
//   mem_read, mem_write    register access requests (write wins when both are high)
//   mem_address, mem_wdata byte offset and write data
//   mem_rdata, mem_resp    registered read data and one-cycle completion pulse
module perf_counter_bank
  import rv32i_types::*;
#(
  parameter int NUM_CNT     = 9,
  parameter int CNT_WIDTH   = 32,
  parameter bit SAT_DEFAULT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] event_i,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [7:0]         mem_address,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_resp
);

  localparam bit HAS_HI = (CNT_WIDTH > 32);

  logic               wr_en, rd_en, aligned, idx_ok;
  logic               lo_hit, hi_hit, ovf_hit, ctrl_hit, clear_all;
  logic [4:0]         idx;
  perf_ctrl_t         wr_ctrl, rd_ctrl;
  logic [NUM_CNT-1:0] inc, ld_lo, ld_hi, ovf_set, w1c;

  logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];
  logic [31:0]          cnt_lo  [NUM_CNT];
  logic [31:0]          cnt_hi  [NUM_CNT];

  logic               freeze_q, freeze_d;
  logic               sat_q, sat_d;
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [31:0]        snap_q, snap_d;
  logic               resp_q, resp_d;
  logic [31:0]        rdata_q, rdata_d;

  always_comb begin
    wr_en     = mem_write;
    rd_en     = mem_read & ~mem_write;
    idx       = mem_address[6:2];
    aligned   = (mem_address[1:0] == 2'b00);
    idx_ok    = ({1'b0, idx} < 6'(NUM_CNT));
    ovf_hit   = (mem_address == PERF_OVF_ADDR);
    ctrl_hit  = (mem_address == PERF_CTRL_ADDR);
    lo_hit    = (mem_address < PERF_HI_BASE) && aligned && idx_ok;
    // The ovf/ctrl registers sit inside the high-word window and take precedence.
    hi_hit    = HAS_HI && (mem_address >= PERF_HI_BASE) && aligned && idx_ok
                && !ovf_hit && !ctrl_hit;
    wr_ctrl   = perf_ctrl_t'(mem_wdata[2:0]);
    clear_all = wr_en && ctrl_hit && wr_ctrl.clear_all;
    w1c       = (wr_en && ovf_hit) ? mem_wdata[NUM_CNT-1:0] : '0;
    inc       = '0;
    ld_lo     = '0;
    ld_hi     = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      inc[k]   = event_i[k] & ~freeze_q;
      ld_lo[k] = wr_en && lo_hit && (idx == 5'(k));
      ld_hi[k] = wr_en && hi_hit && (idx == 5'(k));
    end
  end

  generate
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
      perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (inc[g]),
        .load    (mem_wdata),
        .load_hi (ld_hi[g]),
        .load_lo (ld_lo[g]),
        .clear   (clear_all),
        .saturate(sat_q),
        .value   (cnt_val[g]),
        .ovf_set (ovf_set[g])
      );
      if (HAS_HI) begin : g_wide
        assign cnt_lo[g] = cnt_val[g][31:0];
        assign cnt_hi[g] = 32'(cnt_val[g][CNT_WIDTH-1:32]);
      end else begin : g_narrow
        assign cnt_lo[g] = 32'(cnt_val[g]);
        assign cnt_hi[g] = '0;
      end
    end
  endgenerate

  always_comb begin
    freeze_d = freeze_q;
    sat_d    = sat_q;
    if (wr_en && ctrl_hit) begin
      freeze_d = wr_ctrl.freeze;
      sat_d    = wr_ctrl.saturate;
    end
    // A fresh overflow in the same cycle survives a write-1-to-clear.
    ovf_d   = clear_all ? '0 : ((ovf_q & ~w1c) | ovf_set);
    resp_d  = mem_read | mem_write;
    rdata_d = '0;
    snap_d  = snap_q;
    rd_ctrl = '{clear_all: 1'b0, saturate: sat_q, freeze: freeze_q};
    if (rd_en) begin
      if (lo_hit) begin
        // Latch the upper bits now so a following high-word read matches this low word.
        for (int k = 0; k < NUM_CNT; k++) begin
          if (idx == 5'(k)) begin
            rdata_d = cnt_lo[k];
            snap_d  = cnt_hi[k];
          end
        end
      end else if (hi_hit) begin
        rdata_d = snap_q;
      end else if (ovf_hit) begin
        rdata_d = 32'(ovf_q);
      end else if (ctrl_hit) begin
        rdata_d = 32'(rd_ctrl);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freeze_q <= 1'b0;
      sat_q    <= SAT_DEFAULT;
      ovf_q    <= '0;
      snap_q   <= '0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      freeze_q <= freeze_d;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
      snap_q   <= snap_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - self-checking bench for perf_counter_bank (32-bit and 48-bit instances)
module tb_perf_counter_bank;

  localparam int N = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  event_i = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [7:0]    mem_address = '0;
  logic [31:0]   mem_wdata = '0;
  logic [31:0]   rdata32, rdata48;
  logic          resp32, resp48;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(32), .SAT_DEFAULT(1'b0)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .event_i(event_i), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(rdata32), .mem_resp(resp32));

  perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(48), .SAT_DEFAULT(1'b1)) u_dut48 (
    .clk(clk), .rst_n(rst_n), .event_i(event_i), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(rdata48), .mem_resp(resp48));

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = 32-bit bank, index 1 = 48-bit bank.
  int unsigned     m_w[2]   = '{32, 48};
  bit              m_sdef[2] = '{1'b0, 1'b1};
  longint unsigned m_cnt[2][N];
  logic [N-1:0]    m_ovf[2];
  bit              m_frz[2], m_sat[2];
  longint unsigned m_snap[2];
  bit              exp_resp[2];
  logic [31:0]     exp_rdata[2];

  function automatic longint unsigned wmask(input int unsigned w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < N; k++) m_cnt[i][k] = 0;
      m_ovf[i] = '0; m_frz[i] = 1'b0; m_sat[i] = m_sdef[i]; m_snap[i] = 0;
      exp_resp[i] = 1'b0; exp_rdata[i] = '0;
    end
  endtask

  task automatic model_step();
    bit rd, wr, clr;
    int a, lo_k, hi_k;
    longint unsigned mask, c;
    logic [N-1:0] setb, w1c;
    rd = mem_read && !mem_write;
    wr = mem_write;
    a  = int'(mem_address);
    for (int i = 0; i < 2; i++) begin
      mask = wmask(m_w[i]);
      lo_k = -1; hi_k = -1;
      if (a % 4 == 0 && a < 4 * N) lo_k = a / 4;
      if (m_w[i] > 32 && a % 4 == 0 && a >= 128 && a < 128 + 4 * N && a != 248 && a != 252)
        hi_k = (a - 128) / 4;
      exp_resp[i]  = rd || wr;
      exp_rdata[i] = '0;
      if (rd) begin
        if (lo_k >= 0) begin
          exp_rdata[i] = 32'(m_cnt[i][lo_k]);
          m_snap[i]    = m_cnt[i][lo_k] >> 32;
        end else if (hi_k >= 0) exp_rdata[i] = 32'(m_snap[i]);
        else if (a == 248)      exp_rdata[i] = 32'(m_ovf[i]);
        else if (a == 252)      exp_rdata[i] = {30'd0, m_sat[i], m_frz[i]};
      end
      clr  = wr && a == 252 && mem_wdata[2];
      setb = '0;
      w1c  = (wr && a == 248) ? mem_wdata[N-1:0] : '0;
      for (int k = 0; k < N; k++) begin
        c = m_cnt[i][k];
        if (clr) c = 0;
        else if (wr && lo_k == k) c = (((c >> 32) << 32) | 64'(mem_wdata)) & mask;
        else if (wr && hi_k == k) c = ((c & 64'hFFFF_FFFF) | (64'(mem_wdata) << 32)) & mask;
        else if (event_i[k] && !m_frz[i]) begin
          if (c == mask) begin
            setb[k] = 1'b1;
            c = m_sat[i] ? mask : 0;
          end else c = c + 1;
        end
        m_cnt[i][k] = c;
      end
      m_ovf[i] = clr ? '0 : ((m_ovf[i] & ~w1c) | setb);
      if (wr && a == 252) begin
        m_frz[i] = mem_wdata[0];
        m_sat[i] = mem_wdata[1];
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("resp32", {31'd0, resp32}, {31'd0, exp_resp[0]});
      check("resp48", {31'd0, resp48}, {31'd0, exp_resp[1]});
      if (exp_resp[0]) check("rdata32", rdata32, exp_rdata[0]);
      if (exp_resp[1]) check("rdata48", rdata48, exp_rdata[1]);
    end
  end

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    mem_write = 1'b1; mem_address = a; mem_wdata = d;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] r32, output logic [31:0] r48);
    mem_read = 1'b1; mem_address = a;
    @(negedge clk);
    r32 = rdata32; r48 = rdata48;
    mem_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] r32, r48;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_resp32", {31'd0, resp32}, 32'd0);
    check("rst_rdata48", rdata48, 32'd0);
    rst_n = 1'b1;

    // first edge after release accepts a request
    do_read(8'hFC, r32, r48);
    check("ctrl_rst32", r32, 32'h0);
    check("ctrl_rst48", r48, 32'h2);
    do_read(8'h00, r32, r48);
    check("cnt0_rst48", r48, 32'h0);

    // wrap
    do_write(8'hFC, 32'h0);
    do_write(8'h08, 32'hFFFF_FFFE);
    event_i = 9'h004; idle(3); event_i = '0;
    do_read(8'h08, r32, r48);
    check("wrap_lo32", r32, 32'h0000_0001);
    check("wrap_lo48", r48, 32'h0000_0001);
    do_read(8'hF8, r32, r48);
    check("wrap_ovf32", r32, 32'h4);
    check("wrap_ovf48", r48, 32'h0);
    do_read(8'h88, r32, r48);
    check("wrap_hi32", r32, 32'h0);
    check("wrap_hi48", r48, 32'h1);

    // saturate
    do_write(8'hF8, 32'h1FF);
    do_write(8'hFC, 32'h2);
    do_write(8'h88, 32'h0);
    do_write(8'h08, 32'hFFFF_FFFE);
    event_i = 9'h004; idle(3); event_i = '0;
    do_read(8'h08, r32, r48);
    check("sat_lo32", r32, 32'hFFFF_FFFF);
    check("sat_lo48", r48, 32'h0000_0001);
    do_read(8'hF8, r32, r48);
    check("sat_ovf32", r32, 32'h4);
    do_write(8'hF8, 32'h4);
    do_read(8'hF8, r32, r48);
    check("w1c_ovf32", r32, 32'h0);
    check("w1c_ovf48", r48, 32'h0);

    // coherent snapshot across a carry
    do_write(8'h80, 32'h0);
    event_i = 9'h001;
    do_write(8'h00, 32'hFFFF_FFFF);
    do_read(8'h00, r32, r48);
    check("snap_lo48", r48, 32'hFFFF_FFFF);
    check("snap_lo32", r32, 32'hFFFF_FFFF);
    do_read(8'h80, r32, r48);
    check("snap_hi48", r48, 32'h0);
    event_i = '0;

    // write beats same-cycle event
    event_i = 9'h002;
    do_write(8'h04, 32'h10);
    event_i = '0;
    do_read(8'h04, r32, r48);
    check("prio32", r32, 32'h10);
    check("prio48", r48, 32'h10);

    // freeze, then clear_all under events
    do_write(8'h0C, 32'h5);
    do_write(8'hFC, 32'h1);
    event_i = '1; idle(10);
    do_read(8'h0C, r32, r48);
    check("frz32", r32, 32'h5);
    check("frz48", r48, 32'h5);
    do_write(8'hFC, 32'h0);
    idle(3);
    do_write(8'hFC, 32'h4);
    do_read(8'h0C, r32, r48);
    check("clr32", r32, 32'h0);
    check("clr48", r48, 32'h0);
    do_read(8'hFC, r32, r48);
    check("clr_ctrl32", r32, 32'h0);
    event_i = '0;

    // randomized traffic against the model
    for (int it = 0; it < 1500; it++) begin
      int op, sel, k;
      logic [7:0] a;
      logic [31:0] d;
      event_i = N'($urandom) | N'($urandom);
      op  = $urandom_range(0, 9);
      sel = $urandom_range(0, 5);
      k   = $urandom_range(0, N - 1);
      case (sel)
        0, 1:    a = 8'(4 * k);
        2:       a = 8'(128 + 4 * k);
        3:       a = 8'hF8;
        4:       a = 8'hFC;
        default: a = 8'($urandom_range(0, 255));
      endcase
      if (a == 8'hFC)
        d = {29'd0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0)};
      else if (sel < 2)
        d = $urandom_range(0, 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      else if (sel == 2)
        d = $urandom_range(0, 1) ? 32'h0000_FFFF : $urandom;
      else
        d = $urandom;
      mem_address = a;
      mem_wdata   = d;
      mem_read    = (op <= 3) || (op == 6);
      mem_write   = (op == 4) || (op == 5) || (op == 6);
      @(negedge clk);
    end
    mem_read = 1'b0; mem_write = 1'b0; event_i = '0;
    idle(2);

    // reset with a response in flight
    do_write(8'hFC, 32'h3);
    mem_read = 1'b1; mem_address = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_resp32", {31'd0, resp32}, 32'd0);
    check("rst_async_resp48", {31'd0, resp48}, 32'd0);
    check("rst_async_rdata32", rdata32, 32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    do_read(8'hFC, r32, r48);
    check("post_ctrl32", r32, 32'h0);
    check("post_ctrl48", r48, 32'h2);
    do_read(8'h00, r32, r48);
    check("post_cnt0_32", r32, 32'h0);
    do_read(8'hF8, r32, r48);
    check("post_ovf48", r48, 32'h0);
    do_read(8'h80, r32, r48);
    check("post_snap48", r48, 32'h0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
